// File: rtl/csa_accumulator.sv
// Multi-operand accumulator that keeps the running sum in carry-save form (S, Cs)
// and resolves the carries with a ripple-free iterative pass once the job closes.
module csa_accumulator #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   op_valid,
  input  logic [WIDTH-1:0]       op_data,
  input  logic                   op_last,
  output logic                   op_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH+CNT_W-1:0] result,
  output logic [CNT_W:0]         op_count,
  output logic                   trunc,
  output logic                   busy
);

  localparam int OUT_W = WIDTH + CNT_W;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCUM   = 2'd1;
  localparam logic [1:0] RESOLVE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [CNT_W:0] COUNT_LIMIT = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0] COUNT_ONE   = {{CNT_W{1'b0}}, 1'b1};

  function automatic logic [OUT_W-1:0] csa_sum(
    input logic [OUT_W-1:0] a,
    input logic [OUT_W-1:0] b,
    input logic [OUT_W-1:0] c
  );
    csa_sum = a ^ b ^ c;
  endfunction

  // Carry word is returned already weighted (shifted left one place).
  function automatic logic [OUT_W-1:0] csa_carry(
    input logic [OUT_W-1:0] a,
    input logic [OUT_W-1:0] b,
    input logic [OUT_W-1:0] c
  );
    logic [OUT_W-1:0] maj;
    maj       = (a & b) | (a & c) | (b & c);
    csa_carry = {maj[OUT_W-2:0], 1'b0};
  endfunction

  logic [1:0]       state;
  logic [OUT_W-1:0] s_reg;
  logic [OUT_W-1:0] cs_reg;
  logic [CNT_W:0]   count_reg;
  logic             trunc_reg;

  logic [OUT_W-1:0] operand;
  logic [CNT_W:0]   count_inc;
  logic             accept;
  logic             at_limit;

  assign operand   = {{CNT_W{1'b0}}, op_data};
  assign count_inc = count_reg + COUNT_ONE;
  assign accept    = (state == ACCUM) && op_valid;
  assign at_limit  = (count_inc == COUNT_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_reg     <= '0;
      cs_reg    <= '0;
      count_reg <= '0;
      trunc_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            s_reg     <= '0;
            cs_reg    <= '0;
            count_reg <= '0;
            trunc_reg <= 1'b0;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            s_reg     <= csa_sum(s_reg, cs_reg, operand);
            cs_reg    <= csa_carry(s_reg, cs_reg, operand);
            count_reg <= count_inc;
            if (op_last) begin
              trunc_reg <= 1'b0;
              state     <= RESOLVE;
            end else if (at_limit) begin
              trunc_reg <= 1'b1;
              state     <= RESOLVE;
            end
          end
        end
        RESOLVE: begin
          // Each pass pushes every pending carry at least one bit higher.
          if (cs_reg == '0) begin
            state <= DONE;
          end else begin
            s_reg  <= s_reg ^ cs_reg;
            cs_reg <= {s_reg[OUT_W-2:0] & cs_reg[OUT_W-2:0], 1'b0};
          end
        end
        DONE: begin
          if (res_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign op_ready  = (state == ACCUM);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = s_reg;
  assign op_count  = count_reg;
  assign trunc     = trunc_reg;

endmodule

// File: tb/tb_csa_accumulator.sv
// Randomised and directed bench for csa_accumulator; expected sums come from plain integer addition.
module tb_csa_accumulator;

  localparam int WIDTH = 6;
  localparam int CNT_W = 4;
  localparam int OUT_W = WIDTH + CNT_W;
  localparam int MAX_OPS = 1 << CNT_W;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             op_valid;
  logic [WIDTH-1:0] op_data;
  logic             op_last;
  logic             op_ready;
  logic             res_valid;
  logic             res_ready;
  logic [OUT_W-1:0] result;
  logic [CNT_W:0]   op_count;
  logic             trunc;
  logic             busy;

  int tests_run = 0;
  int fails = 0;

  logic [WIDTH-1:0] job_ops [MAX_OPS];
  int               job_n;
  bit               job_last;
  int               job_bubble_max;

  int               obs_accepts;
  int               obs_resolve;
  logic             obs_ready_at_start;
  logic             obs_ready_after;
  logic [OUT_W-1:0] obs_s;
  logic [OUT_W-1:0] obs_cs;

  csa_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_valid (op_valid),
    .op_data  (op_data),
    .op_last  (op_last),
    .op_ready (op_ready),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .result   (result),
    .op_count (op_count),
    .trunc    (trunc),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job from IDLE and stops once DONE is reached (or the bound expires).
  task automatic drive_job();
    int nb;
    start = 1'b1;
    step();
    start = 1'b0;
    obs_ready_at_start = op_ready;
    obs_accepts = 0;
    for (int i = 0; i < job_n; i++) begin
      nb = (job_bubble_max > 0) ? $urandom_range(job_bubble_max, 0) : 0;
      repeat (nb) step();
      op_valid = 1'b1;
      op_data  = job_ops[i];
      op_last  = job_last && (i == job_n - 1);
      if (!op_ready) break;
      step();
      obs_accepts++;
      op_valid = 1'b0;
      op_last  = 1'b0;
    end
    op_valid = 1'b0;
    op_last  = 1'b0;
    obs_ready_after = op_ready;
    obs_s  = dut.s_reg;
    obs_cs = dut.cs_reg;
    obs_resolve = 0;
    while (!res_valid && obs_resolve < OUT_W + 4) begin
      obs_resolve++;
      step();
    end
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; op_valid = 1'b1; op_data = 6'd9; op_last = 1'b0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    tests_run++;
    if ({busy, op_ready, res_valid, trunc} !== 4'b0000 || result !== '0 || op_count !== '0) begin
      fails++;
      $display("FAIL reset_outputs: busy/rdy/vld/trunc=%b result=%0d count=%0d required 0000/0/0",
               {busy, op_ready, res_valid, trunc}, result, op_count);
    end
    start = 1'b0; op_valid = 1'b0;
    #2 rst_n = 1'b1;
    step();
    tests_run++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle_hold: busy=%b required 0", busy);
    end
  endtask

  task automatic test_basic_sum();
    job_n = 3; job_last = 1; job_bubble_max = 0;
    job_ops[0] = 6'd7; job_ops[1] = 6'd14; job_ops[2] = 6'd28;
    drive_job();
    tests_run++;
    if (obs_ready_at_start !== 1'b1) begin
      fails++;
      $display("FAIL basic_ready: op_ready=%b required 1", obs_ready_at_start);
    end
    tests_run++;
    if (obs_s !== 10'd25 || obs_cs !== 10'd24) begin
      fails++;
      $display("FAIL basic_csa_state: S=%0d Cs=%0d required S=25 Cs=24", obs_s, obs_cs);
    end
    tests_run++;
    if (obs_resolve !== 3) begin
      fails++;
      $display("FAIL basic_resolve_cycles: got %0d required 3", obs_resolve);
    end
    tests_run++;
    if (res_valid !== 1'b1 || result !== 10'd49 || op_count !== 5'd3 || trunc !== 1'b0) begin
      fails++;
      $display("FAIL basic_result: vld=%b result=%0d count=%0d trunc=%b required 1/49/3/0",
               res_valid, result, op_count, trunc);
    end
    release_result();
    tests_run++;
    if (busy !== 1'b0 || result !== 10'd49 || op_count !== 5'd3) begin
      fails++;
      $display("FAIL basic_hold: busy=%b result=%0d count=%0d required 0/49/3", busy, result, op_count);
    end
  endtask

  task automatic test_count_limit();
    job_n = MAX_OPS; job_last = 0; job_bubble_max = 0;
    for (int i = 0; i < MAX_OPS; i++) job_ops[i] = 6'd63;
    drive_job();
    tests_run++;
    if (obs_accepts !== 16 || obs_ready_after !== 1'b0) begin
      fails++;
      $display("FAIL limit_ready_drop: accepts=%0d op_ready=%b required 16/0", obs_accepts, obs_ready_after);
    end
    tests_run++;
    if (result !== 10'd1008 || op_count !== 5'd16 || trunc !== 1'b1) begin
      fails++;
      $display("FAIL limit_result: result=%0d count=%0d trunc=%b required 1008/16/1", result, op_count, trunc);
    end
    release_result();
    op_valid = 1'b1; op_data = 6'd5;
    step(); step();
    op_valid = 1'b0;
    tests_run++;
    if (op_count !== 5'd16 || busy !== 1'b0 || trunc !== 1'b1) begin
      fails++;
      $display("FAIL idle_ignores_valid: count=%0d busy=%b trunc=%b required 16/0/1", op_count, busy, trunc);
    end
  endtask

  task automatic test_bubbles();
    job_n = 5; job_last = 1; job_bubble_max = 3;
    for (int i = 0; i < 5; i++) job_ops[i] = 6'(i + 1);
    drive_job();
    tests_run++;
    if (res_valid !== 1'b1 || result !== 10'd15 || op_count !== 5'd5 || trunc !== 1'b0) begin
      fails++;
      $display("FAIL bubbles_result: vld=%b result=%0d count=%0d trunc=%b required 1/15/5/0",
               res_valid, result, op_count, trunc);
    end
    release_result();
  endtask

  task automatic test_single_zero();
    job_n = 1; job_last = 1; job_bubble_max = 0;
    job_ops[0] = 6'd0;
    drive_job();
    tests_run++;
    if (obs_resolve !== 1) begin
      fails++;
      $display("FAIL zero_resolve_cycles: got %0d required 1", obs_resolve);
    end
    tests_run++;
    if (result !== 10'd0 || op_count !== 5'd1 || trunc !== 1'b0) begin
      fails++;
      $display("FAIL zero_result: result=%0d count=%0d trunc=%b required 0/1/0", result, op_count, trunc);
    end
    release_result();
  endtask

  task automatic test_back_pressure();
    job_n = 2; job_last = 1; job_bubble_max = 0;
    job_ops[0] = 6'd10; job_ops[1] = 6'd20;
    drive_job();
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      step();
      tests_run++;
      if (res_valid !== 1'b1 || result !== 10'd30 || op_count !== 5'd2) begin
        fails++;
        $display("FAIL hold_in_done cycle %0d: vld=%b result=%0d count=%0d required 1/30/2",
                 k, res_valid, result, op_count);
      end
    end
    start = 1'b0;
    release_result();
    tests_run++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || op_ready !== 1'b0) begin
      fails++;
      $display("FAIL done_to_idle: busy=%b vld=%b rdy=%b required 0/0/0", busy, res_valid, op_ready);
    end
    step();
    tests_run++;
    if (busy !== 1'b0 || result !== 10'd30) begin
      fails++;
      $display("FAIL start_ignored_in_done: busy=%b result=%0d required 0/30", busy, result);
    end
  endtask

  task automatic test_reset_mid_job();
    start = 1'b1; step(); start = 1'b0;
    op_valid = 1'b1; op_data = 6'd33; step();
    op_data = 6'd17; step();
    op_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, op_ready, res_valid, trunc} !== 4'b0000 || result !== '0 || op_count !== '0) begin
      fails++;
      $display("FAIL reset_mid_accum: busy/rdy/vld/trunc=%b result=%0d count=%0d required 0000/0/0",
               {busy, op_ready, res_valid, trunc}, result, op_count);
    end
    #2 rst_n = 1'b1;
    job_n = 2; job_last = 1; job_bubble_max = 0;
    job_ops[0] = 6'd3; job_ops[1] = 6'd4;
    drive_job();
    tests_run++;
    if (obs_ready_at_start !== 1'b1 || result !== 10'd7 || op_count !== 5'd2) begin
      fails++;
      $display("FAIL after_reset_job: rdy=%b result=%0d count=%0d required 1/7/2",
               obs_ready_at_start, result, op_count);
    end
    release_result();
    // Reset again while carries are still being resolved.
    start = 1'b1; step(); start = 1'b0;
    op_valid = 1'b1; op_data = 6'd63; op_last = 1'b0; step();
    op_last = 1'b1; step();
    op_valid = 1'b0; op_last = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || result !== '0 || op_count !== '0) begin
      fails++;
      $display("FAIL reset_mid_resolve: busy=%b result=%0d count=%0d required 0/0/0", busy, result, op_count);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_random_jobs();
    int exp_sum;
    bit exp_trunc;
    for (int j = 0; j < 12; j++) begin
      job_n = $urandom_range(MAX_OPS, 1);
      job_last = (job_n < MAX_OPS) ? 1'b1 : bit'($urandom_range(1, 0));
      job_bubble_max = $urandom_range(2, 0);
      exp_sum = 0;
      for (int i = 0; i < job_n; i++) begin
        job_ops[i] = WIDTH'($urandom_range(63, 0));
        exp_sum += int'(job_ops[i]);
      end
      exp_trunc = !job_last;
      drive_job();
      tests_run++;
      if (res_valid !== 1'b1 || result !== OUT_W'(exp_sum) || op_count !== (CNT_W+1)'(job_n)
          || trunc !== exp_trunc) begin
        fails++;
        $display("FAIL random_job %0d: vld=%b result=%0d count=%0d trunc=%b required 1/%0d/%0d/%0b",
                 j, res_valid, result, op_count, trunc, exp_sum, job_n, exp_trunc);
      end
      tests_run++;
      if (obs_resolve > OUT_W + 1) begin
        fails++;
        $display("FAIL random_resolve_bound %0d: cycles=%0d required <=%0d", j, obs_resolve, OUT_W + 1);
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_count_limit();
    test_bubbles();
    test_single_zero();
    test_back_pressure();
    test_reset_mid_job();
    test_random_jobs();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/csa_accumulator.md
CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, giving the operand width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 4: at most 2^CNT_W operands per job; OUT_W = WIDTH+CNT_W.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port start  input  1  begin a new job; sampled in IDLE only.
REQ-007 The block SHALL have port op_valid  input  1  op_data is valid.
REQ-008 The block SHALL have port op_data  input  WIDTH  unsigned operand.
REQ-009 The block SHALL have port op_last  input  1  qualifies the final operand of a job.
REQ-010 The block SHALL have port op_ready  output  1  block accepts an operand this cycle.
REQ-011 The block SHALL have port res_valid  output  1  result is valid.
REQ-012 The block SHALL have port res_ready  input  1  consumer accepts the result.
REQ-013 The block SHALL have port result  output  OUT_W  exact sum of the job's operands.
REQ-014 The block SHALL have port op_count  output  CNT_W+1  number of operands accepted in the current or last job.
REQ-015 The block SHALL have port trunc  output  1  job ended on the count limit without op_last.
REQ-016 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 The block SHALL hold internal registers S and Cs, each OUT_W bits; Cs holds carries already shifted left by one.
REQ-018 The block SHALL implement FSM states IDLE, ACCUM, RESOLVE and DONE.
REQ-019 IDLE: op_ready=0 and res_valid=0; start=1 SHALL clear S, Cs, op_count and trunc and enter ACCUM on the next edge.
REQ-020 ACCUM: op_ready SHALL be 1; an operand is accepted on any edge where op_valid&op_ready=1.
REQ-021 On accept, with x = op_data zero-extended to OUT_W: S<=S^Cs^x; Cs<=(maj(S,Cs,x))<<1, truncated to OUT_W; op_count<=op_count+1.
REQ-022 An accept with op_last=1 SHALL enter RESOLVE with trunc=0.
REQ-023 The accept that brings op_count to 2^CNT_W SHALL enter RESOLVE; trunc<=~op_last on that accept.
REQ-024 op_valid=0 cycles in ACCUM SHALL leave all state unchanged, with no timeout.
REQ-025 RESOLVE, each cycle: if Cs==0, enter DONE; otherwise S<=S^Cs and Cs<=(S&Cs)<<1.
REQ-026 RESOLVE SHALL terminate within OUT_W+1 cycles.
REQ-027 DONE: res_valid=1 and result=S, stable until res_ready=1; the res_valid&res_ready edge SHALL return to IDLE.
REQ-028 On leaving DONE, result, op_count and trunc SHALL hold their values until the next start.
REQ-029 start SHALL be ignored in ACCUM, RESOLVE and DONE.
REQ-030 op_valid SHALL be ignored outside ACCUM, since op_ready=0 there.
REQ-031 result SHALL equal the exact sum mod 2^OUT_W; this is always exact because the sum of at most 2^CNT_W operands is below 2^OUT_W.
REQ-032 op_ready, res_valid and busy SHALL be decoded from the state register only, with no combinational path from any input.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE and zero S, Cs, result, op_count, trunc, op_ready, res_valid and busy, in any state, including mid-ACCUM and mid-RESOLVE.
REQ-034 After rst_n rises, the first start SHALL be honoured on the first rising edge.

Verification (WIDTH=6, CNT_W=4, OUT_W=10)
REQ-035 The bench SHALL cover: start; operands 7, 14, 28, with op_last on 28 -> after the accept, S=25 and Cs=24; RESOLVE takes 3 cycles; result=49, op_count=3, trunc=0.
REQ-036 The bench SHALL cover: 16 operands of 63, op_last=0 throughout -> op_ready drops after the 16th accept; result=1008, op_count=16, trunc=1.
REQ-037 The bench SHALL cover: operands 1..5 with op_valid bubbles of 0-3 cycles between them, op_last on 5 -> result=15, op_count=5.
REQ-038 The bench SHALL cover: single operand 0 with op_last -> RESOLVE lasts 1 cycle; result=0, op_count=1.
REQ-039 The bench SHALL cover: res_ready held low for 5 cycles in DONE, with start pulsed meanwhile -> res_valid and result stay stable, start has no effect, and the state is IDLE after res_ready rises.
REQ-040 The bench SHALL cover: rst_n pulsed low after 2 accepts -> all outputs 0 asynchronously; a subsequent job of operands 3, 4 -> result=7.
